lfsr_delay_timer: RTL and testbench

Consumes the 7-bit pseudo-random word from the LFSR stage and converts it into a random wait interval, counted in time-base ticks. Sits directly downstream of the LFSR and upstream of the lights/reaction FSM:
- Armed by a trigger.
- Counts down the sampled value.
- Fires a one-cycle time_out pulse.
- Requests an LFSR advance so the next interval differs.

---
 rtl/lfsr_delay_pkg.sv | 21 ++
 rtl/delay_down_counter.sv | 43 ++++
 rtl/lfsr_delay_timer.sv | 122 ++++++++++++
 tb/tb_lfsr_delay_timer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_delay_pkg.sv
// Shared types and helpers for the LFSR-driven random delay timer.
// The timer state machine walks IDLE -> LOAD -> COUNT -> DONE -> IDLE.
// The down counter is WIDTH + SCALE_SHIFT bits wide, so a shifted sample
// always fits and can never wrap.
package lfsr_delay_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } delay_state_t;

    localparam int DEFAULT_WIDTH = 7;

    // Counter width needed to hold a random word after it has been scaled up.
    function automatic int counterWidth(input int width, input int scaleShift);
        return width + scaleShift;
    endfunction

endpackage

// File: rtl/delay_down_counter.sv
// Loadable down counter for the random delay timer.
// Clear has priority over load, and load has priority over decrement.
// Decrementing stops at zero, so the counter never wraps.
// The zero and one flags let the controlling FSM spot the last tick.
module delay_down_counter
    import lfsr_delay_pkg::*;
#(
    parameter int CW = counterWidth(DEFAULT_WIDTH, 0)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          zero,
    output logic          one
);

    logic [CW-1:0] r_count;

    // Remaining-tick register: clear on abort, load on trigger, count down on honoured ticks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - CW'(1);
        end
    end

    // Flags decoded from the register, used by the FSM to spot the final tick.
    always_comb begin
        count = r_count;
        zero  = (r_count == '0);
        one   = (r_count == CW'(1));
    end

endmodule

// File: rtl/lfsr_delay_timer.sv
// Random delay timer.
// On a trigger it samples the LFSR word and scales it into a tick count.
// It counts the scaled value down on time-base ticks, fires a one-cycle
// time_out pulse, and asks the LFSR to advance.
// Optional macro LFSR_DELAY_FREE_RUN_EN: when defined, lfsr_en is also high
// in every IDLE cycle after reset, so the LFSR free-runs between triggers.
// All outputs decode registered state only.
module lfsr_delay_timer
    import lfsr_delay_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SCALE_SHIFT = 0,
    parameter int MIN_DELAY   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         trigger,
    input  logic                         abort,
    input  logic                         tick,
    input  logic [WIDTH-1:0]             rnd_in,
    output logic                         lfsr_en,
    output logic                         busy,
    output logic                         time_out,
    output logic [WIDTH+SCALE_SHIFT-1:0] count_out
);

    localparam int CW = counterWidth(WIDTH, SCALE_SHIFT);

    delay_state_t  r_state;
    delay_state_t  w_nextState;
    logic [CW-1:0] w_scaled;
    logic [CW-1:0] w_loadVal;
    logic          w_running;
    logic          w_load;
    logic          w_clear;
    logic          w_dec;
    logic          w_zero;
    logic          w_one;

    delay_down_counter #(
        .CW(CW)
    ) u_counter (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_clear),
        .load    (w_load),
        .load_val(w_loadVal),
        .dec     (w_dec),
        .count   (count_out),
        .zero    (w_zero),
        .one     (w_one)
    );

    // Scale the sampled word; a zero sample would give no wait, so substitute MIN_DELAY.
    always_comb begin
        w_scaled  = CW'(rnd_in) << SCALE_SHIFT;
        w_loadVal = (rnd_in == '0) ? CW'(MIN_DELAY) : w_scaled;
    end

    // Counter control: load in IDLE on trigger, clear on abort while running, tick down in COUNT.
    always_comb begin
        w_running = (r_state == LOAD) || (r_state == COUNT);
        w_load    = (r_state == IDLE) && trigger;
        w_clear   = w_running && abort;
        w_dec     = (r_state == COUNT) && tick && !abort && !w_zero;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: abort beats the final tick, and triggers outside IDLE are dropped.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (trigger) w_nextState = LOAD;
            LOAD:    w_nextState = abort ? IDLE : COUNT;
            COUNT: begin
                if (abort) begin
                    w_nextState = IDLE;
                end else if (tick && w_one) begin
                    w_nextState = DONE;
                end
            end
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

`ifdef LFSR_DELAY_FREE_RUN_EN
    logic r_live;

    // Holds off free-running until the first clock after reset, so lfsr_en reads 0 in reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    // Output decode: the LFSR advances in DONE and in every IDLE cycle.
    always_comb begin
        busy     = w_running;
        time_out = (r_state == DONE);
        lfsr_en  = (r_state == DONE) || ((r_state == IDLE) && r_live);
    end
`else
    // Output decode: the LFSR advances only once per completed interval.
    always_comb begin
        busy     = w_running;
        time_out = (r_state == DONE);
        lfsr_en  = (r_state == DONE);
    end
`endif

endmodule

// File: tb/tb_lfsr_delay_timer.sv
// Self-checking bench for lfsr_delay_timer.
// A behavioural interval model is compared against the default instance on
// every negative clock edge. Directed literal expectations pin the model,
// and a second instance exercises SCALE_SHIFT and MIN_DELAY.
module tb_lfsr_delay_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       trigger, abort, tick;
    logic [6:0] rndIn;
    logic       lfsrEn, busy, timeOut;
    logic [6:0] countOut;

    logic       sTrigger, sAbort, sTick;
    logic [6:0] sRnd;
    logic       sLfsrEn, sBusy, sTimeOut;
    logic [8:0] sCount;

    int testsRun      = 0;
    int testsFailed   = 0;
    int timeoutPulses = 0;
    int lfsrPulses    = 0;
    bit checkEn       = 1'b0;

    // Model state: whether an interval is running, its first (tick-blind) cycle,
    // the ticks still owed, the end-of-interval pulse, and whether reset has been left.
    bit mActive    = 1'b0;
    bit mGrace     = 1'b0;
    bit mPulse     = 1'b0;
    bit mLive      = 1'b0;
    int mRemaining = 0;

    always #5 clk = ~clk;

    lfsr_delay_timer u_dut (
        .clk      (clk),
        .rst      (rst),
        .trigger  (trigger),
        .abort    (abort),
        .tick     (tick),
        .rnd_in   (rndIn),
        .lfsr_en  (lfsrEn),
        .busy     (busy),
        .time_out (timeOut),
        .count_out(countOut)
    );

    lfsr_delay_timer #(
        .WIDTH      (7),
        .SCALE_SHIFT(2),
        .MIN_DELAY  (3)
    ) u_dutScaled (
        .clk      (clk),
        .rst      (rst),
        .trigger  (sTrigger),
        .abort    (sAbort),
        .tick     (sTick),
        .rnd_in   (sRnd),
        .lfsr_en  (sLfsrEn),
        .busy     (sBusy),
        .time_out (sTimeOut),
        .count_out(sCount)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Inputs for the next edge are driven 1 time unit after the current edge.
    task automatic applyStimulus(input bit t, input bit a, input bit k, input logic [6:0] r);
        @(posedge clk);
        #1;
        trigger = t;
        abort   = a;
        tick    = k;
        rndIn   = r;
    endtask

    task automatic applyScaled(input bit t, input bit k, input logic [6:0] r);
        @(posedge clk);
        #1;
        sTrigger = t;
        sTick    = k;
        sRnd     = r;
    endtask

    // Returns how many calls it took until time_out was seen (-1 if never).
    task automatic runUntilTimeout(input int tickEvery, input logic [6:0] r, output int cycles);
        cycles = -1;
        for (int i = 1; i <= 200; i++) begin
            applyStimulus(1'b0, 1'b0, (i % tickEvery) == 0, r);
            if (timeOut === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic runScaledUntilTimeout(output int cycles);
        cycles = -1;
        for (int i = 1; i <= 200; i++) begin
            applyScaled(1'b0, 1'b1, sRnd);
            if (sTimeOut === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    // Interval model: advances on each clock from the inputs seen at that edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mActive    = 1'b0;
            mGrace     = 1'b0;
            mPulse     = 1'b0;
            mLive      = 1'b0;
            mRemaining = 0;
        end else begin
            mLive = 1'b1;
            if (mPulse) begin
                mPulse = 1'b0;
            end else if (!mActive) begin
                if (trigger) begin
                    mActive    = 1'b1;
                    mGrace     = 1'b1;
                    mRemaining = (rndIn == 0) ? 1 : int'(rndIn);
                end
            end else if (abort) begin
                mActive    = 1'b0;
                mGrace     = 1'b0;
                mRemaining = 0;
            end else if (mGrace) begin
                mGrace = 1'b0;
            end else if (tick) begin
                mRemaining = mRemaining - 1;
                if (mRemaining == 0) begin
                    mActive = 1'b0;
                    mPulse  = 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison of the default instance against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("model_busy", busy, int'(mActive));
            checkOutput("model_time_out", timeOut, int'(mPulse));
            checkOutput("model_count_out", countOut, mRemaining);
`ifdef LFSR_DELAY_FREE_RUN_EN
            checkOutput("model_lfsr_en", lfsrEn, int'(mPulse || (!mActive && mLive)));
`else
            checkOutput("model_lfsr_en", lfsrEn, int'(mPulse));
`endif
            if (timeOut === 1'b1) timeoutPulses++;
            if (lfsrEn === 1'b1) lfsrPulses++;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d failed so far", testsFailed);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cycles;
        trigger = 0; abort = 0; tick = 0; rndIn = 0;
        sTrigger = 0; sAbort = 0; sTick = 0; sRnd = 0;
        #1 rst = 1'b0;
        checkEn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_time_out", timeOut, 0);
        checkOutput("reset_lfsr_en", lfsrEn, 0);
        checkOutput("reset_count_out", countOut, 0);
        checkOutput("reset_scaled_count", sCount, 0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Test 1: rnd=5, tick every cycle.
        applyStimulus(0, 0, 0, 7'd5);
        applyStimulus(1, 0, 1, 7'd5);
        applyStimulus(0, 0, 1, 7'd5);
        checkOutput("t1_load_count", countOut, 5);
        checkOutput("t1_load_busy", busy, 1);
        runUntilTimeout(1, 7'd5, cycles);
        checkOutput("t1_cycles_to_timeout", cycles, 6);
        checkOutput("t1_lfsr_en_at_done", lfsrEn, 1);
        applyStimulus(0, 0, 0, 7'd5);
        checkOutput("t1_busy_after", busy, 0);
        checkOutput("t1_time_out_after", timeOut, 0);

        // Test 2: a zero sample loads MIN_DELAY=1.
        applyStimulus(1, 0, 1, 7'd0);
        applyStimulus(0, 0, 1, 7'd0);
        checkOutput("t2_min_delay_load", countOut, 1);
        runUntilTimeout(1, 7'd0, cycles);
        checkOutput("t2_cycles_to_timeout", cycles, 2);

        // Test 3: rnd=2, tick every 4th cycle.
        applyStimulus(0, 0, 0, 7'd2);
        applyStimulus(1, 0, 0, 7'd2);
        runUntilTimeout(4, 7'd2, cycles);
        checkOutput("t3_cycles_to_timeout", cycles, 9);

        // Test 4a: abort at count_out=3.
        applyStimulus(0, 0, 0, 7'd5);
        applyStimulus(1, 0, 1, 7'd5);
        applyStimulus(0, 0, 1, 7'd5);
        applyStimulus(0, 0, 1, 7'd5);
        applyStimulus(0, 0, 1, 7'd5);
        applyStimulus(0, 1, 1, 7'd5);
        checkOutput("t4_count_before_abort", countOut, 3);
        applyStimulus(0, 0, 1, 7'd5);
        checkOutput("t4_abort_busy", busy, 0);
        checkOutput("t4_abort_count", countOut, 0);
        checkOutput("t4_abort_time_out", timeOut, 0);
        repeat (3) applyStimulus(0, 0, 1, 7'd5);

        // Test 4b: abort together with the final tick.
        applyStimulus(1, 0, 1, 7'd1);
        applyStimulus(0, 0, 1, 7'd1);
        applyStimulus(0, 1, 1, 7'd1);
        checkOutput("t4b_count_at_one", countOut, 1);
        applyStimulus(0, 0, 0, 7'd1);
        checkOutput("t4b_time_out", timeOut, 0);
        checkOutput("t4b_busy", busy, 0);
        applyStimulus(0, 0, 0, 7'd1);
        checkOutput("t4b_time_out_later", timeOut, 0);

        // Test 5a: a trigger during COUNT is ignored.
        applyStimulus(1, 0, 1, 7'd6);
        applyStimulus(0, 0, 1, 7'd6);
        applyStimulus(1, 0, 1, 7'd9);
        applyStimulus(0, 0, 1, 7'd9);
        checkOutput("t5_no_reload", countOut, 5);
        runUntilTimeout(1, 7'd9, cycles);
        checkOutput("t5_cycles_to_timeout", cycles, 5);

        // Test 5b: asynchronous reset mid-COUNT.
        applyStimulus(0, 0, 0, 7'd8);
        applyStimulus(1, 0, 1, 7'd8);
        applyStimulus(0, 0, 1, 7'd8);
        applyStimulus(0, 0, 1, 7'd8);
        applyStimulus(0, 0, 1, 7'd8);
        checkOutput("t5b_count_before_reset", countOut, 7);
        #2 rst = 1'b0;
        #1;
        checkOutput("t5b_async_busy", busy, 0);
        checkOutput("t5b_async_count", countOut, 0);
        checkOutput("t5b_async_time_out", timeOut, 0);
        checkOutput("t5b_async_lfsr_en", lfsrEn, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        applyStimulus(0, 0, 0, 7'd8);
        applyStimulus(0, 0, 0, 7'd8);
        checkOutput("t5b_idle_after_reset", busy, 0);

        // Test 6: LFSR advance requests across the completed intervals.
        checkOutput("t6_completed_intervals", timeoutPulses, 4);
`ifdef LFSR_DELAY_FREE_RUN_EN
        checkOutput("t6_free_run_idle", lfsrEn, 1);
`else
        checkOutput("t6_one_lfsr_pulse_each", lfsrPulses, timeoutPulses);
`endif

        // Scaled instance: SCALE_SHIFT=2, rnd=3 loads 12.
        applyScaled(1, 1, 7'd3);
        applyScaled(0, 1, 7'd3);
        checkOutput("s_load_count", sCount, 12);
        checkOutput("s_load_busy", sBusy, 1);
        runScaledUntilTimeout(cycles);
        checkOutput("s_cycles_to_timeout", cycles, 13);
        checkOutput("s_lfsr_en_at_done", sLfsrEn, 1);

        // Scaled instance: a zero sample loads MIN_DELAY=3.
        applyScaled(0, 1, 7'd0);
        applyScaled(1, 1, 7'd0);
        applyScaled(0, 1, 7'd0);
        checkOutput("s_min_delay_load", sCount, 3);
        runScaledUntilTimeout(cycles);
        checkOutput("s_min_cycles_to_timeout", cycles, 4);

        repeat (2) applyStimulus(0, 0, 0, 7'd0);
        checkEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
